// File: rtl/rv32i_mem_pkg.sv
// rtl/rv32i_mem_pkg.sv - shared RV32I data-memory access constants, state encoding and checks
package rv32i_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_t;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_H, F3_HU: return addr_lo[0];
            F3_W:        return (addr_lo != 2'b00);
            default:     return 1'b0;
        endcase
    endfunction

    // Unsigned variants only exist for loads.
    function automatic logic is_bad_funct3(input logic [2:0] funct3, input logic we);
        case (funct3)
            F3_B, F3_H, F3_W: return 1'b0;
            F3_BU, F3_HU:     return we;
            default:          return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane write mask/replication and load extraction/extension
module dmem_lane_align
    import rv32i_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wword,
    output logic [31:0] ldata
);

    logic [31:0] byte_sel;
    logic [31:0] half_sel;

    assign byte_sel = rword >> {addr_lo, 3'b000};
    assign half_sel = rword >> {addr_lo[1], 4'b0000};

    // Store data is replicated across lanes so the mask alone picks the destination.
    always_comb begin
        byte_en = 4'b0000;
        wword   = wdata;
        case (funct3)
            F3_B, F3_BU: begin
                byte_en = 4'b0001 << addr_lo;
                wword   = {4{wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
                wword   = {2{wdata[15:0]}};
            end
            F3_W: begin
                byte_en = 4'b1111;
                wword   = wdata;
            end
            default: begin
                byte_en = 4'b0000;
                wword   = wdata;
            end
        endcase
    end

    always_comb begin
        ldata = rword;
        case (funct3)
            F3_B:    ldata = {{24{byte_sel[7]}}, byte_sel[7:0]};
            F3_BU:   ldata = {24'h0, byte_sel[7:0]};
            F3_H:    ldata = {{16{half_sel[15]}}, half_sel[15:0]};
            F3_HU:   ldata = {16'h0, half_sel[15:0]};
            default: ldata = rword;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency word RAM responder for the MEM-stage data interface
module dmem_responder
    import rv32i_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = 5;
    // One extra count so the response appears LATENCY+1 edges after acceptance.
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY + 1);

    dmem_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          commit;

    logic          cap_we_q;
    logic [31:0]   cap_addr_q;
    logic [31:0]   cap_wdata_q;
    logic [2:0]    cap_funct3_q;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [29:0]   word_idx;
    logic [AW-1:0] ram_idx;
    logic          in_range;
    logic          acc_err;
    logic [31:0]   rd_word;
    logic [3:0]    byte_en;
    logic [31:0]   wword;
    logic [31:0]   ldata;

    assign word_idx = cap_addr_q[31:2];
    assign ram_idx  = cap_addr_q[AW+1:2];
    assign in_range = (word_idx < 30'(DEPTH_WORDS));
    assign acc_err  = is_bad_funct3(cap_funct3_q, cap_we_q)
                    | is_misaligned(cap_funct3_q, cap_addr_q[1:0])
                    | ~in_range;
    assign rd_word  = in_range ? mem[ram_idx] : 32'h0;

    dmem_lane_align u_lane_align (
        .funct3  (cap_funct3_q),
        .addr_lo (cap_addr_q[1:0]),
        .wdata   (cap_wdata_q),
        .rword   (rd_word),
        .byte_en (byte_en),
        .wword   (wword),
        .ldata   (ldata)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        commit    = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    commit  = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            rdata_q      <= 32'h0;
            err_q        <= 1'b0;
            cap_we_q     <= 1'b0;
            cap_addr_q   <= 32'h0;
            cap_wdata_q  <= 32'h0;
            cap_funct3_q <= 3'b000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == ST_IDLE && req_valid) begin
                cap_we_q     <= req_we;
                cap_addr_q   <= req_addr;
                cap_wdata_q  <= req_wdata;
                cap_funct3_q <= req_funct3;
            end
            if (commit) begin
                err_q   <= acc_err;
                rdata_q <= (acc_err || cap_we_q) ? 32'h0 : ldata;
            end
        end
    end

    // RAM contents deliberately survive reset; reset only blocks a pending commit.
    always_ff @(posedge clk) begin
        if (!rst && commit && cap_we_q && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[ram_idx][8*i +: 8] <= wword[8*i +: 8];
                end
            end
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder with a byte-array reference model
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [2:0]  req_funct3 = 3'b000;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        z_req_valid = 1'b0;
    logic        z_req_ready;
    logic        z_req_we = 1'b0;
    logic [31:0] z_req_addr = 32'h0;
    logic [31:0] z_req_wdata = 32'h0;
    logic [2:0]  z_req_funct3 = 3'b000;
    logic        z_rsp_valid;
    logic        z_rsp_ready = 1'b1;
    logic [31:0] z_rsp_rdata;
    logic        z_rsp_err;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_funct3(z_req_funct3),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  bmem [0:4*DEPTH-1];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        prev_v = 1'b0;
    logic        rdy_force_en = 1'b0;
    logic        rdy_force_val = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: memory as a flat byte array, RV32I rules applied directly.
    task automatic model(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] f3, output logic [31:0] rd, output logic err);
        int size;
        logic [31:0] v;
        size = 0;
        err  = 1'b0;
        rd   = 32'h0;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    err = 1'b1;
        endcase
        if (we && f3 >= 3'd4) err = 1'b1;
        if (size != 0 && (a % size) != 0) err = 1'b1;
        if ((a >> 2) >= DEPTH) err = 1'b1;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < size; i++) bmem[a + i] = wd[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < size; i++) v = v | (32'(bmem[a + i]) << (8*i));
                if (f3 < 3'd4 && size < 4 && v[8*size-1]) v = v | ~((32'h1 << (8*size)) - 1);
                rd = v;
            end
        end
    endtask

    task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] f3);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL req_ready_timeout: got 0 expected 1");
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = a;
        req_wdata  = wd;
        req_funct3 = f3;
        @(posedge clk);
        #1;
        model(we, a, wd, f3, e.rdata, e.err);
        e.acc = cyc;
        exp_q.push_back(e);
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_funct3 = 3'($urandom);
    endtask

    always @(posedge clk) begin
        #1;
        if (rdy_force_en) rsp_ready = rdy_force_val;
        else rsp_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: latency on each rising rsp_valid, data/err on each response handshake.
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (rsp_valid && !prev_v) begin
                if (exp_q.size() == 0) check("unexpected_rsp", 32'(rsp_valid), 32'h0);
                else check("latency", 32'(cyc - exp_q[0].acc), 32'(LAT + 1));
            end
            if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
                check("rsp_rdata", rsp_rdata, exp_q[0].rdata);
                check("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
                void'(exp_q.pop_front());
            end
            prev_v = rsp_valid;
        end
    end

    task automatic l0_req(input string name, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] f3,
                          input logic [31:0] exp_rd, input logic exp_err);
        @(negedge clk);
        check({name, "_ready"}, 32'(z_req_ready), 32'h1);
        z_req_valid  = 1'b1;
        z_req_we     = we;
        z_req_addr   = a;
        z_req_wdata  = wd;
        z_req_funct3 = f3;
        @(posedge clk);
        #1;
        z_req_valid = 1'b0;
        z_req_addr  = $urandom;
        @(negedge clk);
        check({name, "_early"}, 32'(z_rsp_valid), 32'h0);
        @(negedge clk);
        check({name, "_valid"}, 32'(z_rsp_valid), 32'h1);
        check({name, "_rdata"}, z_rsp_rdata, exp_rd);
        check({name, "_err"}, 32'(z_rsp_err), 32'(exp_err));
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] hold_d;
        logic        hold_e;
        int          n;
        logic [31:0] a;
        logic [2:0]  f3;

        for (int i = 0; i < 4*DEPTH; i++) bmem[i] = 8'h00;
        rdy_force_en = 1'b1;
        rdy_force_val = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'h1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_rsp_err", 32'(rsp_err), 32'h0);
        #1 rst = 1'b0;

        for (int w = 0; w < 32; w++) do_req(1'b1, 32'(w*4), 32'h0, 3'b010);

        do_req(1'b1, 32'h10, 32'hDEADBEEF, 3'b010);
        do_req(1'b0, 32'h10, 32'h0, 3'b010);
        do_req(1'b1, 32'h20, 32'h11223344, 3'b010);
        do_req(1'b1, 32'h21, 32'h000000AA, 3'b000);
        do_req(1'b0, 32'h20, 32'h0, 3'b010);
        do_req(1'b0, 32'h21, 32'h0, 3'b000);
        do_req(1'b0, 32'h21, 32'h0, 3'b100);
        do_req(1'b0, 32'h22, 32'h0, 3'b001);
        do_req(1'b1, 32'h23, 32'hFFFF5555, 3'b001);
        do_req(1'b0, 32'h20, 32'h0, 3'b010);
        do_req(1'b0, 32'h20, 32'h0, 3'b011);
        do_req(1'b0, 32'(DEPTH*4), 32'h0, 3'b010);

        // LATENCY=0 instance, directed.
        l0_req("l0_sw", 1'b1, 32'h0, 32'hCAFEF00D, 3'b010, 32'h0, 1'b0);
        l0_req("l0_lw", 1'b0, 32'h0, 32'h0, 3'b010, 32'hCAFEF00D, 1'b0);
        l0_req("l0_lh", 1'b0, 32'h2, 32'h0, 3'b001, 32'hFFFFCAFE, 1'b0);

        // Response stall: outputs frozen while rsp_ready is low.
        rdy_force_val = 1'b0;
        @(negedge clk);
        do_req(1'b0, 32'h20, 32'h0, 3'b010);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("stall_valid_seen", 32'(rsp_valid), 32'h1);
        hold_d = rsp_rdata;
        hold_e = rsp_err;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_valid", 32'(rsp_valid), 32'h1);
            check("stall_rdata", rsp_rdata, hold_d);
            check("stall_err", 32'(rsp_err), 32'(hold_e));
            check("stall_req_ready", 32'(req_ready), 32'h0);
        end
        rdy_force_val = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("release_req_ready", 32'(req_ready), 32'h1);
        check("release_rsp_valid", 32'(rsp_valid), 32'h0);

        // Reset during WAIT discards the store.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 32'h30;
        req_wdata  = 32'h12345678;
        req_funct3 = 3'b010;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("wait_req_ready", 32'(req_ready), 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_wait_req_ready", 32'(req_ready), 32'h1);
        check("rst_wait_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_wait_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_wait_rsp_err", 32'(rsp_err), 32'h0);
        do_req(1'b0, 32'h30, 32'h0, 3'b010);

        // Randomized traffic with random response backpressure.
        rdy_force_en = 1'b0;
        for (int t = 0; t < 250; t++) begin
            if ($urandom_range(0, 9) == 0) a = 32'((DEPTH + $urandom_range(0, 100)) * 4 + $urandom_range(0, 3));
            else a = 32'($urandom_range(0, 127));
            if ($urandom_range(0, 9) < 8) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            do_req(1'($urandom), a, $urandom, f3);
        end

        n = 0;
        while ((exp_q.size() != 0 || !req_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
